oqpsk_bit_feeder: RTL and testbench
===================================

Name: oqpsk_bit_feeder

Overview:
- Upstream stage of the OQPSK raised-cosine modulator. Buffers parallel data words and serialises them MSB-first.
- Supplies one bit per modulator request on a REQ/ACK handshake.
- Drives the modulator's enable (EN_OUT) and bit input (BIT_OUT).
- Flags underflow when the modulator requests a bit and none is available.

Parameters:
- DATA_W, 32: width of each input word, in bits.
- FIFO_DEPTH, 4: number of words the FIFO holds. Must be a power of 2 and at least 2.
- CNT_W, $clog2(DATA_W*(FIFO_DEPTH+1))+1: width of the LEVEL output.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- WR_DATA  input  DATA_W  word to enqueue.
- WR_VALID  input  1  WR_DATA is valid this cycle.
- WR_READY  output  1  FIFO can accept a word.
- REQ_BIT  input  1  modulator requests the next bit. Sampled every cycle.
- BIT_OUT  output  1  serial bit to the modulator Bit_In.
- BIT_ACK  output  1  BIT_OUT is valid. One-cycle pulse.
- EN_OUT  output  1  bits are available. Drives the modulator EN.
- LEVEL  output  CNT_W  number of bits buffered (FIFO bits plus shift-register bits).
- UNDERFLOW  output  1  sticky underflow flag.
- CLR_UFLOW  input  1  synchronous clear of UNDERFLOW.

Behaviour:
- Reset: while RST=0, all outputs are 0 and WR_READY=0; FIFO and shift register are empty. WR_READY=1 on the first cycle after RST deasserts. Reset asserted mid-operation discards all buffered data and any pending ACK.
- Write side: a word is accepted when WR_VALID & WR_READY. WR_READY = !fifo_full, decoded from registered state. A write to a full FIFO is not accepted, even in a cycle where a pop also occurs.
- FIFO: read and write pointers are log2(FIFO_DEPTH) bits plus 1 wrap bit. Full = MSBs differ and the rest are equal. Empty = pointers equal.
- Shift register: holds DATA_W bits plus a bit counter sh_cnt in 0..DATA_W. States:
  - EMPTY (sh_cnt=0): if the FIFO is non-empty, pop the FIFO, load the word, set sh_cnt=DATA_W, go to SHIFT (1-cycle load).
  - SHIFT: on REQ_BIT, register BIT_OUT=MSB, shift left, sh_cnt--.
    - If sh_cnt goes to 0 and the FIFO is non-empty, reload on the same edge (no bubble) and stay in SHIFT.
    - Otherwise go to EMPTY.
- Handshake latency: REQ_BIT high at edge n gives BIT_ACK=1 and valid BIT_OUT during cycle n+1.
  - BIT_OUT holds its value until the next ACK.
  - REQ_BIT held high gives one bit per cycle.
- Underflow: REQ_BIT while sh_cnt=0 still produces BIT_ACK=1 at n+1, with BIT_OUT=0, and sets UNDERFLOW.
  - UNDERFLOW stays set until CLR_UFLOW=1.
  - If CLR_UFLOW and a new underflow occur in the same cycle, set wins.
- EN_OUT: registered (LEVEL_next != 0). A write into an empty block raises EN_OUT 1 cycle after acceptance; LEVEL counts the FIFO word immediately.
- LEVEL: fifo_count*DATA_W + sh_cnt, registered, updated every cycle.
- Simultaneous write and pop: both take effect, and the count is unchanged.

Optional Feature:
- Macro: OQPSK_FEEDER_PRBS_EN.
- When defined: adds input PRBS_SEL (1 bit) and a PRBS-9 generator (x^9+x^5+1, seed 9'h1FF on reset).
  - With PRBS_SEL=1, each REQ_BIT returns the next PRBS bit with the same 1-cycle ACK latency.
  - EN_OUT=1, UNDERFLOW never sets, and the FIFO and shift register are untouched; writes are still accepted.
  - The LFSR advances only on REQ_BIT while PRBS_SEL=1.
- When undefined: no PRBS_SEL port and no LFSR logic.

Decomposition:
- Package oqpsk_pkg holds:
  - OQPSK_DATA_W=32 and OQPSK_FIFO_DEPTH=4 defaults.
  - OQPSK_IQ_W=13, the modulator sample width.
  - PRBS9 seed and tap constants.
  - Feeder state enum {ST_EMPTY, ST_SHIFT}.
- One sub-module: oqpsk_word_fifo (parameterised synchronous FIFO with push/pop, full/empty and count). The shift FSM, handshake and flags live in the top.

Test Plan:
- Reset, write 32'hA5A5_0F0F, hold REQ_BIT for 32 cycles -> bits 1,0,1,0,0,1,0,1,...,1,1,1,1 each with BIT_ACK; EN_OUT falls after the last bit; LEVEL goes 32→0.
- Fill 4 words until WR_READY=0, then 1 more write -> the 5th word is rejected. After all 5*32=160 requests, 160 bits match the first 4 words plus the preloaded word with no gap between words; UNDERFLOW=0.
- With empty buffers, pulse REQ_BIT -> BIT_ACK=1 and BIT_OUT=0 next cycle, UNDERFLOW=1. Pulse CLR_UFLOW -> UNDERFLOW=0. Assert CLR_UFLOW together with a new underflow -> UNDERFLOW=1.
- Write a word on the same cycle the last bit of the previous word is requested -> next REQ gets the new MSB with no underflow.
- Assert RST mid-word (after 10 bits) -> all outputs 0, LEVEL=0, and EN_OUT stays 0 until the next write.
- With OQPSK_FEEDER_PRBS_EN and PRBS_SEL=1, 511 requests -> the sequence matches the PRBS-9 model from seed 1FF and repeats at bit 512; FIFO LEVEL is unchanged.

Source files
------------

// File: rtl/oqpsk_pkg.sv
// oqpsk_pkg: shared defaults, PRBS-9 constants and feeder state type for the OQPSK modulator front end
package oqpsk_pkg;
    localparam int OQPSK_DATA_W = 32;
    localparam int OQPSK_FIFO_DEPTH = 4;
    localparam int OQPSK_IQ_W = 13;
    localparam logic [8:0] PRBS9_SEED = 9'h1FF;
    localparam int PRBS9_TAP_A = 8;
    localparam int PRBS9_TAP_B = 4;
    typedef enum logic {ST_EMPTY, ST_SHIFT} state_t;
endpackage

// File: rtl/oqpsk_word_fifo.sv
// oqpsk_word_fifo: synchronous word FIFO with wrap-bit pointers, full/empty and occupancy count
module oqpsk_word_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
endmodule

// File: rtl/oqpsk_bit_feeder.sv
// oqpsk_bit_feeder: buffers words and feeds them MSB-first to the OQPSK modulator; OQPSK_FEEDER_PRBS_EN adds a PRBS-9 source
module oqpsk_bit_feeder import oqpsk_pkg::*; #(
    parameter int DATA_W = OQPSK_DATA_W,
    parameter int FIFO_DEPTH = OQPSK_FIFO_DEPTH,
    parameter int CNT_W = $clog2(DATA_W*(FIFO_DEPTH+1))+1
) (
    input  logic              CLK,
    input  logic              RST,
`ifdef OQPSK_FEEDER_PRBS_EN
    input  logic              PRBS_SEL,
`endif
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              WR_VALID,
    output logic              WR_READY,
    input  logic              REQ_BIT,
    output logic              BIT_OUT,
    output logic              BIT_ACK,
    output logic              EN_OUT,
    output logic [CNT_W-1:0]  LEVEL,
    output logic              UNDERFLOW,
    input  logic              CLR_UFLOW
);
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(DATA_W + 1);
    logic full, empty, push, pop, ready_q, prbs, prbs_bit, shift;
    logic [DATA_W-1:0] rdata, sh_reg;
    logic [SW-1:0] sh_cnt, sh_cnt_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic [CNT_W-1:0] level_n;
    state_t state;
`ifdef OQPSK_FEEDER_PRBS_EN
    logic [8:0] lfsr;
    assign prbs = PRBS_SEL;
    assign prbs_bit = lfsr[8];
    always_ff @(posedge CLK or negedge RST)
        if (!RST) lfsr <= PRBS9_SEED;
        else if (PRBS_SEL && REQ_BIT) lfsr <= {lfsr[7:0], lfsr[PRBS9_TAP_A] ^ lfsr[PRBS9_TAP_B]};
`else
    assign prbs = 1'b0;
    assign prbs_bit = 1'b0;
`endif
    assign WR_READY = ready_q && !full;
    oqpsk_word_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLK), .rst_n(RST), .push(push), .pop(pop), .wdata(WR_DATA),
        .rdata(rdata), .full(full), .empty(empty), .count(fcnt)
    );
    // Pop either to fill an idle shifter or to reload on the last bit so words run back to back
    always_comb begin
        push = WR_VALID && WR_READY;
        shift = !prbs && REQ_BIT && state == ST_SHIFT;
        pop = !prbs && !empty && (state == ST_EMPTY || (shift && sh_cnt == SW'(1)));
        sh_cnt_n = pop ? SW'(DATA_W) : shift ? sh_cnt - SW'(1) : sh_cnt;
        fcnt_n = fcnt + FW'(push) - FW'(pop);
        level_n = CNT_W'(fcnt_n) * CNT_W'(DATA_W) + CNT_W'(sh_cnt_n);
    end
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            ready_q <= 1'b0;
            state <= ST_EMPTY;
            sh_reg <= '0;
            sh_cnt <= '0;
            BIT_OUT <= 1'b0;
            BIT_ACK <= 1'b0;
            EN_OUT <= 1'b0;
            LEVEL <= '0;
            UNDERFLOW <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            BIT_ACK <= REQ_BIT;
            LEVEL <= level_n;
            EN_OUT <= prbs || level_n != '0;
            sh_cnt <= sh_cnt_n;
            if (REQ_BIT) BIT_OUT <= prbs ? prbs_bit : state == ST_SHIFT && sh_reg[DATA_W-1];
            if (pop) begin
                sh_reg <= rdata;
                state <= ST_SHIFT;
            end else if (shift) begin
                sh_reg <= sh_reg << 1;
                if (sh_cnt == SW'(1)) state <= ST_EMPTY;
            end
            if (!prbs && REQ_BIT && state == ST_EMPTY) UNDERFLOW <= 1'b1;
            else if (CLR_UFLOW) UNDERFLOW <= 1'b0;
        end
endmodule

// File: tb/tb_oqpsk_bit_feeder.sv
// tb_oqpsk_bit_feeder: directed self-checking bench for oqpsk_bit_feeder
module tb_oqpsk_bit_feeder;
    logic clk = 1'b0, rst = 1'b0;
    logic [31:0] wr_data = '0;
    logic wr_valid = 1'b0, req_bit = 1'b0, clr_uflow = 1'b0;
    logic wr_ready, bit_out, bit_ack, en_out, underflow;
    logic [8:0] level;
    int tests = 0, fails = 0;
    logic [31:0] words [6];
`ifdef OQPSK_FEEDER_PRBS_EN
    logic prbs_sel = 1'b0;
    logic [8:0] m;
    logic first_bit;
`endif

    oqpsk_bit_feeder dut (
        .CLK(clk), .RST(rst),
`ifdef OQPSK_FEEDER_PRBS_EN
        .PRBS_SEL(prbs_sel),
`endif
        .WR_DATA(wr_data), .WR_VALID(wr_valid), .WR_READY(wr_ready),
        .REQ_BIT(req_bit), .BIT_OUT(bit_out), .BIT_ACK(bit_ack), .EN_OUT(en_out),
        .LEVEL(level), .UNDERFLOW(underflow), .CLR_UFLOW(clr_uflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        words[0] = 32'h1234_5678;
        words[1] = 32'hDEAD_BEEF;
        words[2] = 32'h0F0F_F0F0;
        words[3] = 32'h8000_0001;
        words[4] = 32'hCAFE_F00D;
        words[5] = 32'h5555_AAAA;
        repeat (2) tick();
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_en", 32'(en_out), 0);
        chk("rst_ack", 32'(bit_ack), 0);
        rst = 1'b1;
        tick();
        chk("post_rst_wr_ready", 32'(wr_ready), 1);
        chk("post_rst_en", 32'(en_out), 0);
        // single word A5A5_0F0F
        wr_data = 32'hA5A5_0F0F;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("w1_level", 32'(level), 32);
        chk("w1_en", 32'(en_out), 1);
        tick();
        req_bit = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            chk($sformatf("w1_bit%0d", i), 32'(bit_out), 32'(wr_data[31-i]));
            chk($sformatf("w1_ack%0d", i), 32'(bit_ack), 1);
            chk($sformatf("w1_lvl%0d", i), 32'(level), 32'(31 - i));
            chk($sformatf("w1_en%0d", i), 32'(en_out), 32'(i != 31));
        end
        req_bit = 1'b0;
        tick();
        chk("w1_ack_low", 32'(bit_ack), 0);
        chk("w1_hold", 32'(bit_out), 1);
        chk("w1_uflow", 32'(underflow), 0);
        // preload one word, fill FIFO, then a rejected write
        wr_data = words[0];
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        for (int k = 1; k < 5; k++) begin
            wr_data = words[k];
            wr_valid = 1'b1;
            tick();
        end
        chk("fill_ready", 32'(wr_ready), 0);
        chk("fill_level", 32'(level), 160);
        wr_data = words[5];
        tick();
        wr_valid = 1'b0;
        chk("reject_level", 32'(level), 160);
        req_bit = 1'b1;
        for (int i = 0; i < 160; i++) begin
            tick();
            chk($sformatf("fill_bit%0d", i), 32'(bit_out), 32'(words[i/32][31 - i%32]));
            chk($sformatf("fill_ack%0d", i), 32'(bit_ack), 1);
        end
        req_bit = 1'b0;
        chk("fill_uflow", 32'(underflow), 0);
        chk("fill_level_end", 32'(level), 0);
        tick();
        // underflow set, clear, and set-wins
        req_bit = 1'b1;
        tick();
        req_bit = 1'b0;
        chk("uf_ack", 32'(bit_ack), 1);
        chk("uf_bit", 32'(bit_out), 0);
        chk("uf_set", 32'(underflow), 1);
        chk("uf_en", 32'(en_out), 0);
        tick();
        chk("uf_sticky", 32'(underflow), 1);
        clr_uflow = 1'b1;
        tick();
        chk("uf_clear", 32'(underflow), 0);
        req_bit = 1'b1;
        tick();
        req_bit = 1'b0;
        chk("uf_set_wins", 32'(underflow), 1);
        tick();
        clr_uflow = 1'b0;
        chk("uf_clear2", 32'(underflow), 0);
        // write landing on the last-bit request
        wr_data = 32'h0000_0001;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        req_bit = 1'b1;
        repeat (31) tick();
        wr_data = 32'hC000_0000;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        req_bit = 1'b0;
        chk("edge_last_bit", 32'(bit_out), 1);
        chk("edge_level", 32'(level), 32);
        chk("edge_en", 32'(en_out), 1);
        tick();
        req_bit = 1'b1;
        tick();
        chk("edge_msb", 32'(bit_out), 1);
        chk("edge_ack", 32'(bit_ack), 1);
        chk("edge_uflow", 32'(underflow), 0);
        repeat (2) tick();
        chk("edge_bit2", 32'(bit_out), 0);
        chk("edge_lvl", 32'(level), 29);
        // reset mid-word after 10 bits with buffered data and a pending ack
        repeat (7) tick();
        req_bit = 1'b0;
        wr_data = 32'hFFFF_FFFF;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 22 + 32);
        req_bit = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(bit_ack), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_en", 32'(en_out), 0);
        chk("mid_rst_ready", 32'(wr_ready), 0);
        req_bit = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("after_rst_en", 32'(en_out), 0);
        chk("after_rst_level", 32'(level), 0);
        req_bit = 1'b1;
        tick();
        req_bit = 1'b0;
        chk("after_rst_empty", 32'(underflow), 1);
        clr_uflow = 1'b1;
        wr_data = 32'h8000_0000;
        wr_valid = 1'b1;
        tick();
        clr_uflow = 1'b0;
        wr_valid = 1'b0;
        chk("after_rst_write_en", 32'(en_out), 1);
        chk("after_rst_write_level", 32'(level), 32);
`ifdef OQPSK_FEEDER_PRBS_EN
        tick();
        prbs_sel = 1'b1;
        req_bit = 1'b1;
        m = 9'h1FF;
        first_bit = m[8];
        for (int i = 0; i < 512; i++) begin
            tick();
            chk($sformatf("prbs_bit%0d", i), 32'(bit_out), 32'(m[8]));
            m = {m[7:0], m[8] ^ m[4]};
        end
        chk("prbs_repeat", 32'(bit_out), 32'(first_bit));
        chk("prbs_level", 32'(level), 32);
        chk("prbs_en", 32'(en_out), 1);
        chk("prbs_uflow", 32'(underflow), 0);
        req_bit = 1'b0;
        prbs_sel = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
